pri_icache_ctrl_hub: RTL and testbench

PRI_ICACHE_CTRL_HUB -- requirements
Module: pri_icache_ctrl_hub

---
 rtl/pri_icache_ctrl_hub.sv | 176 +++++++++++++++++
 tb/tb_pri_icache_ctrl_hub.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pri_icache_ctrl_hub.sv
// Control hub for private icache channels: per-core bypass/flush 4-phase handshake
// FSMs, saturating per-core hit/trans/miss counters, and a registered readback port.
module pri_icache_ctrl_hub #(
    parameter int unsigned NB_CORES  = 8,
    parameter int unsigned CNT_WIDTH = 32,
    localparam int unsigned CORE_W   = (NB_CORES > 1) ? $clog2(NB_CORES) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NB_CORES-1:0]  bypass_en_i,
    input  logic [NB_CORES-1:0]  flush_trig_i,
    output logic [NB_CORES-1:0]  bypass_req_o,
    input  logic [NB_CORES-1:0]  bypass_ack_i,
    output logic [NB_CORES-1:0]  flush_req_o,
    input  logic [NB_CORES-1:0]  flush_ack_i,
    output logic [NB_CORES-1:0]  flush_done_o,
    input  logic [NB_CORES-1:0]  hit_i,
    input  logic [NB_CORES-1:0]  trans_i,
    input  logic [NB_CORES-1:0]  miss_i,
    input  logic                 cnt_enable_i,
    input  logic                 cnt_clear_i,
    input  logic [CORE_W-1:0]    rd_core_i,
    input  logic [1:0]           rd_sel_i,
    output logic [CNT_WIDTH-1:0] rd_data_o,
    output logic                 idle_o
);

    localparam int unsigned NSLOT = 1 << CORE_W;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_BYP_WAIT   = 3'd1,
        S_BYPASSED   = 3'd2,
        S_EN_WAIT    = 3'd3,
        S_FLUSH_WAIT = 3'd4
    } state_e;

    state_e              state_q [NB_CORES];
    logic [NB_CORES-1:0] ret_byp_q;
    logic [NB_CORES-1:0] pend_q;
    logic [NB_CORES-1:0] byp_req_q;
    logic [NB_CORES-1:0] flush_req_q;
    logic [NB_CORES-1:0] flush_done_q;
    logic [NB_CORES-1:0] core_idle;

    logic [CNT_WIDTH-1:0] hit_cnt_q   [NB_CORES];
    logic [CNT_WIDTH-1:0] trans_cnt_q [NB_CORES];
    logic [CNT_WIDTH-1:0] miss_cnt_q  [NB_CORES];
    logic [CNT_WIDTH-1:0] rd_mux      [NSLOT*4];

    // Per-core handshake FSMs; the trigger pulse itself counts as pending so a
    // flush wins over a same-cycle bypass change.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int c = 0; c < NB_CORES; c++) begin
                state_q[c] <= S_IDLE;
            end
            ret_byp_q    <= '0;
            pend_q       <= '0;
            byp_req_q    <= '0;
            flush_req_q  <= '0;
            flush_done_q <= '0;
        end else begin
            for (int c = 0; c < NB_CORES; c++) begin
                flush_done_q[c] <= 1'b0;
                if (flush_trig_i[c]) begin
                    pend_q[c] <= 1'b1;
                end
                case (state_q[c])
                    S_IDLE: begin
                        if (pend_q[c] || flush_trig_i[c]) begin
                            state_q[c]     <= S_FLUSH_WAIT;
                            ret_byp_q[c]   <= 1'b0;
                            pend_q[c]      <= 1'b0;
                            flush_req_q[c] <= 1'b1;
                        end else if (bypass_en_i[c]) begin
                            state_q[c]   <= S_BYP_WAIT;
                            byp_req_q[c] <= 1'b1;
                        end
                    end
                    S_BYP_WAIT: begin
                        if (bypass_ack_i[c]) begin
                            state_q[c] <= S_BYPASSED;
                        end
                    end
                    S_BYPASSED: begin
                        if (pend_q[c] || flush_trig_i[c]) begin
                            state_q[c]     <= S_FLUSH_WAIT;
                            ret_byp_q[c]   <= 1'b1;
                            pend_q[c]      <= 1'b0;
                            flush_req_q[c] <= 1'b1;
                        end else if (!bypass_en_i[c]) begin
                            state_q[c]   <= S_EN_WAIT;
                            byp_req_q[c] <= 1'b0;
                        end
                    end
                    S_EN_WAIT: begin
                        if (!bypass_ack_i[c]) begin
                            state_q[c] <= S_IDLE;
                        end
                    end
                    S_FLUSH_WAIT: begin
                        // req low inside FLUSH_WAIT means the ack has already been seen high
                        if (flush_req_q[c]) begin
                            if (flush_ack_i[c]) begin
                                flush_req_q[c] <= 1'b0;
                            end
                        end else if (!flush_ack_i[c]) begin
                            flush_done_q[c] <= 1'b1;
                            state_q[c]      <= ret_byp_q[c] ? S_BYPASSED : S_IDLE;
                        end
                    end
                    default: begin
                        state_q[c]     <= S_IDLE;
                        byp_req_q[c]   <= 1'b0;
                        flush_req_q[c] <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Saturating event counters; clear beats a simultaneous increment.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NB_CORES; c++) begin
            if (!rst_ni || cnt_clear_i) begin
                hit_cnt_q[c]   <= '0;
                trans_cnt_q[c] <= '0;
                miss_cnt_q[c]  <= '0;
            end else if (cnt_enable_i) begin
                if (hit_i[c] && (hit_cnt_q[c] != '1)) begin
                    hit_cnt_q[c] <= hit_cnt_q[c] + CNT_WIDTH'(1);
                end
                if (trans_i[c] && (trans_cnt_q[c] != '1)) begin
                    trans_cnt_q[c] <= trans_cnt_q[c] + CNT_WIDTH'(1);
                end
                if (miss_i[c] && (miss_cnt_q[c] != '1)) begin
                    miss_cnt_q[c] <= miss_cnt_q[c] + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Readback table padded to a power of two so unpopulated core slots read zero.
    for (genvar s = 0; s < NSLOT; s++) begin : g_slot
        if (s < NB_CORES) begin : g_core
            logic not_stable;
            assign not_stable       = (state_q[s] != S_IDLE) && (state_q[s] != S_BYPASSED);
            assign core_idle[s]     = !not_stable && !pend_q[s];
            assign rd_mux[4*s + 0]  = hit_cnt_q[s];
            assign rd_mux[4*s + 1]  = trans_cnt_q[s];
            assign rd_mux[4*s + 2]  = miss_cnt_q[s];
            assign rd_mux[4*s + 3]  = CNT_WIDTH'({state_q[s], not_stable, pend_q[s],
                                                  bypass_ack_i[s], byp_req_q[s]});
        end else begin : g_pad
            assign rd_mux[4*s + 0] = '0;
            assign rd_mux[4*s + 1] = '0;
            assign rd_mux[4*s + 2] = '0;
            assign rd_mux[4*s + 3] = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_data_o <= '0;
        end else begin
            rd_data_o <= rd_mux[{rd_core_i, rd_sel_i}];
        end
    end

    assign bypass_req_o = byp_req_q;
    assign flush_req_o  = flush_req_q;
    assign flush_done_o = flush_done_q;
    assign idle_o       = &core_idle;

endmodule

// File: tb/tb_pri_icache_ctrl_hub.sv
// Directed self-checking bench for pri_icache_ctrl_hub (6 cores, 16-bit counters).
module tb_pri_icache_ctrl_hub;

    localparam int unsigned NB = 6;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] bypass_en, flush_trig, bypass_req, bypass_ack;
    logic [NB-1:0] flush_req, flush_ack, flush_done;
    logic [NB-1:0] hit, trans, miss;
    logic          cnt_enable, cnt_clear;
    logic [2:0]    rd_core;
    logic [1:0]    rd_sel;
    logic [CW-1:0] rd_data;
    logic          idle;

    int n_checks = 0;
    int n_pass   = 0;

    pri_icache_ctrl_hub #(.NB_CORES(NB), .CNT_WIDTH(CW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .bypass_en_i  (bypass_en),
        .flush_trig_i (flush_trig),
        .bypass_req_o (bypass_req),
        .bypass_ack_i (bypass_ack),
        .flush_req_o  (flush_req),
        .flush_ack_i  (flush_ack),
        .flush_done_o (flush_done),
        .hit_i        (hit),
        .trans_i      (trans),
        .miss_i       (miss),
        .cnt_enable_i (cnt_enable),
        .cnt_clear_i  (cnt_clear),
        .rd_core_i    (rd_core),
        .rd_sel_i     (rd_sel),
        .rd_data_o    (rd_data),
        .idle_o       (idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Registered read: value is the state visible when the select was applied.
    task automatic rd(input int core, input int sel, output logic [63:0] v);
        rd_core = 3'(core);
        rd_sel  = 2'(sel);
        step();
        v = 64'(rd_data);
    endtask

    logic [63:0] v;
    int          dones;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; bypass_en = '0; flush_trig = '0; bypass_ack = '0; flush_ack = '0;
        hit = '0; trans = '0; miss = '0; cnt_enable = 1'b0; cnt_clear = 1'b0;
        rd_core = '0; rd_sel = '0;
        step(); step();
        chk("rst_byp_req", 64'(bypass_req), 64'h0);
        chk("rst_flush_req", 64'(flush_req), 64'h0);
        chk("rst_flush_done", 64'(flush_done), 64'h0);
        chk("rst_rd_data", 64'(rd_data), 64'h0);
        chk("rst_idle", 64'(idle), 64'h1);
        rst_n = 1'b1;

        // Bypass round trip on core 2
        bypass_en[2] = 1'b1;
        step();
        chk("c2_req_up", 64'(bypass_req[2]), 64'h1);
        step(); step(); step();
        chk("c2_busy", 64'(idle), 64'h0);
        bypass_ack[2] = 1'b1;
        step();
        chk("c2_req_held", 64'(bypass_req[2]), 64'h1);
        chk("c2_idle_byp", 64'(idle), 64'h1);
        rd(2, 3, v);
        chk("c2_stat_byp", v, 64'h23);
        bypass_en[2] = 1'b0;
        step();
        chk("c2_req_down", 64'(bypass_req[2]), 64'h0);
        chk("c2_enwait_busy", 64'(idle), 64'h0);
        rd(2, 3, v);
        chk("c2_stat_enw", v, 64'h3a);
        bypass_ack[2] = 1'b0;
        step();
        chk("c2_idle", 64'(idle), 64'h1);
        rd(2, 3, v);
        chk("c2_stat_idle", v, 64'h0);

        // Flush while bypassed on core 0
        bypass_en[0] = 1'b1;
        step();
        bypass_ack[0] = 1'b1;
        step();
        flush_trig[0] = 1'b1;
        step();
        flush_trig[0] = 1'b0;
        chk("c0_flush_req", 64'(flush_req[0]), 64'h1);
        chk("c0_byp_kept", 64'(bypass_req[0]), 64'h1);
        rd(0, 3, v);
        chk("c0_stat_fw", v, 64'h4b);
        flush_ack[0] = 1'b1;
        step();
        chk("c0_req_drop", 64'(flush_req[0]), 64'h0);
        step();
        chk("c0_no_done_early", 64'(flush_done[0]), 64'h0);
        flush_ack[0] = 1'b0;
        step();
        chk("c0_done", 64'(flush_done[0]), 64'h1);
        step();
        chk("c0_done_pulse", 64'(flush_done[0]), 64'h0);
        rd(0, 3, v);
        chk("c0_stat_back", v, 64'h23);
        bypass_en[0] = 1'b0;
        step();
        bypass_ack[0] = 1'b0;
        step();

        // Flush beats simultaneous bypass enable on core 1
        flush_trig[1] = 1'b1; bypass_en[1] = 1'b1;
        step();
        flush_trig[1] = 1'b0;
        chk("c1_flush_first", 64'(flush_req[1]), 64'h1);
        chk("c1_no_byp", 64'(bypass_req[1]), 64'h0);
        flush_ack[1] = 1'b1;
        step();
        flush_ack[1] = 1'b0;
        step();
        chk("c1_done", 64'(flush_done[1]), 64'h1);
        chk("c1_no_byp_yet", 64'(bypass_req[1]), 64'h0);
        step();
        chk("c1_byp_after", 64'(bypass_req[1]), 64'h1);

        // Two triggers during FLUSH_WAIT on core 3 yield one extra handshake
        flush_trig[3] = 1'b1;
        step();
        flush_trig[3] = 1'b1;
        step();
        flush_trig[3] = 1'b0;
        step();
        flush_trig[3] = 1'b1;
        step();
        flush_trig[3] = 1'b0;
        rd(3, 3, v);
        chk("c3_stat_pend", v, 64'h4c);
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            flush_ack[3] = flush_req[3];
            step();
            if (flush_done[3]) dones++;
        end
        chk("c3_handshakes", 64'(dones), 64'd2);
        chk("c3_req_low", 64'(flush_req[3]), 64'h0);

        // Counters on core 4, enable gating and read latency
        cnt_enable = 1'b0;
        hit[4] = 1'b1;
        step(); step(); step();
        cnt_enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            trans[4] = (i < 2);
            step();
        end
        hit[4] = 1'b0; trans[4] = 1'b0;
        rd(4, 0, v);
        chk("c4_hit", v, 64'd5);
        rd(4, 1, v);
        chk("c4_trans", v, 64'd2);
        rd(4, 2, v);
        chk("c4_miss", v, 64'd0);
        hit[4] = 1'b1;
        rd(4, 0, v);
        hit[4] = 1'b0;
        chk("c4_hit_pre_update", v, 64'd5);
        rd(4, 0, v);
        chk("c4_hit_post_update", v, 64'd6);
        rd(6, 0, v);
        chk("oob_core_cnt", v, 64'd0);
        rd(7, 3, v);
        chk("oob_core_stat", v, 64'd0);

        // Saturation on core 5, then clear overriding a hit pulse
        hit[5] = 1'b1;
        for (int i = 0; i < 65540; i++) step();
        hit[5] = 1'b0;
        rd(5, 0, v);
        chk("c5_hit_sat", v, 64'hffff);
        rd(5, 1, v);
        chk("c5_trans_zero", v, 64'h0);
        cnt_clear = 1'b1; hit[5] = 1'b1;
        step();
        cnt_clear = 1'b0; hit[5] = 1'b0;
        rd(5, 0, v);
        chk("c5_cleared", v, 64'h0);
        rd(4, 0, v);
        chk("c4_cleared", v, 64'h0);

        // Reset while core 1 sits in BYP_WAIT
        chk("c1_in_bypwait", 64'(bypass_req[1]), 64'h1);
        rst_n = 1'b0;
        step();
        chk("c1_rst_req", 64'(bypass_req[1]), 64'h0);
        chk("rst2_idle", 64'(idle), 64'h1);
        bypass_en[1] = 1'b0;
        rst_n = 1'b1;
        rd(1, 3, v);
        chk("c1_rst_stat", v, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
